float_to_int_converter: RTL and testbench

Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter for the FPU. It decodes a float produced by the float add/subtract datapath back into two's-complement integer form. It normalises the mantissa with a 1-bit-per-cycle right shifter under a start/done handshake, and is the integer-side counterpart to the float datapath.

---
 rtl/float_to_int_converter_pkg.sv | 25 ++
 rtl/float_to_int_converter_classify.sv | 41 ++++
 rtl/float_to_int_converter.sv | 141 ++++++++++++++
 tb/tb_float_to_int_converter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/float_to_int_converter_pkg.sv
// Shared constants, FSM encoding and sign helper for the float-to-int converter.
// Build option FLOAT_TO_INT_ROUND_EN is consumed by the classifier and the top.
package float_to_int_converter_pkg;

    localparam logic [31:0] FLOAT_NAN     = 32'h7FC0_0000;
    localparam logic [31:0] FLOAT_INF     = 32'h7F80_0000;
    localparam logic [31:0] FLOAT_INT_MIN = 32'hCF00_0000;
    localparam logic [7:0]  EXP_BIAS      = 8'd127;
    localparam logic [7:0]  EXP_INT_LIMIT = 8'd158;
    localparam logic [31:0] INT_MAX       = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        SHIFT  = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic logic [31:0] twos_neg(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/float_to_int_converter_classify.sv
// Combinational classifier for a single-precision operand: special classes and right-shift count.
// FLOAT_TO_INT_ROUND_EN moves exp=126 out of the "small" class so it can round up.
module float_to_int_converter_classify
    import float_to_int_converter_pkg::*;
(
    input  logic [31:0] fa,
    output logic        sign,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        is_small,
    output logic        is_big,
    output logic [5:0]  n
);

    logic [7:0]  exp;
    logic [22:0] man;

    assign exp  = fa[30:23];
    assign man  = fa[22:0];
    assign sign = fa[31];

    always_comb begin
        is_nan  = (exp == FLOAT_NAN[30:23]) && (man != 23'd0);
        is_inf  = (fa[30:0] == FLOAT_INF[30:0]);
        is_zero = (exp == 8'd0);
        is_big  = (exp >= EXP_INT_LIMIT) && (exp != 8'hFF);
`ifdef FLOAT_TO_INT_ROUND_EN
        is_small = !is_zero && (exp < EXP_BIAS - 8'd1);
`else
        is_small = !is_zero && (exp < EXP_BIAS);
`endif
        // Remaining exponents span 126/127..157, giving a shift of 32/31..1.
        if (is_nan || is_inf || is_zero || is_small || is_big) begin
            n = 6'd0;
        end else begin
            n = 6'(EXP_INT_LIMIT - exp);
        end
    end

endmodule

// File: rtl/float_to_int_converter.sv
// IEEE-754 single to signed 32-bit integer, one mantissa bit shifted per cycle; done n+3 edges after start.
// Build option FLOAT_TO_INT_ROUND_EN: round to nearest even instead of truncating toward zero.
module float_to_int_converter
    import float_to_int_converter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] fa,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        invalid,
    output logic        inexact
);

    state_t      state, state_nx;
    logic [31:0] fa_q, mag, spec_res, dec_res, fin_res, mag_out;
    logic [32:0] mag_rnd;
    logic [5:0]  cnt, cls_n;
    logic        guard, sticky, spec, spec_inv, spec_inx;
    logic        dec_spec, dec_inv, dec_inx, fin_inv, fin_inx, ovf;
    logic        sign, is_nan, is_inf, is_zero, is_small, is_big;

    float_to_int_converter_classify u_classify (
        .fa       (fa_q),
        .sign     (sign),
        .is_nan   (is_nan),
        .is_inf   (is_inf),
        .is_zero  (is_zero),
        .is_small (is_small),
        .is_big   (is_big),
        .n        (cls_n)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Special cases pass through SHIFT with a zero count, which keeps their latency at 3.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = DECODE;
            DECODE:  state_nx = SHIFT;
            SHIFT:   if (cnt == 6'd0) state_nx = FINISH;
            FINISH:  state_nx = DONE;
            DONE:    state_nx = start ? DECODE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dec_spec = 1'b1;
        dec_res  = 32'd0;
        dec_inv  = 1'b0;
        dec_inx  = 1'b0;
        if (is_nan) begin
            dec_inv = 1'b1;
        end else if (is_inf || is_big) begin
            dec_res = sign ? INT_MIN : INT_MAX;
            dec_inv = (fa_q != FLOAT_INT_MIN);
        end else if (is_zero) begin
            dec_inx = (fa_q[22:0] != 23'd0);
        end else if (is_small) begin
            dec_inx = 1'b1;
        end else begin
            dec_spec = 1'b0;
        end
    end

    always_comb begin
`ifdef FLOAT_TO_INT_ROUND_EN
        mag_rnd = {1'b0, mag} + {32'd0, guard & (sticky | mag[0])};
`else
        mag_rnd = {1'b0, mag};
`endif
        ovf     = !sign && (mag_rnd > {1'b0, INT_MAX});
        mag_out = sign ? twos_neg(mag_rnd[31:0]) : mag_rnd[31:0];
        fin_res = spec ? spec_res : (ovf ? INT_MAX : mag_out);
        fin_inv = spec ? spec_inv : ovf;
        fin_inx = spec ? spec_inx : (guard | sticky);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fa_q     <= 32'd0;
            mag      <= 32'd0;
            cnt      <= 6'd0;
            guard    <= 1'b0;
            sticky   <= 1'b0;
            spec     <= 1'b0;
            spec_res <= 32'd0;
            spec_inv <= 1'b0;
            spec_inx <= 1'b0;
            result   <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fa_q <= fa;
                        busy <= 1'b1;
                    end
                end
                DECODE: begin
                    mag      <= {1'b1, fa_q[22:0], 8'd0};
                    cnt      <= cls_n;
                    guard    <= 1'b0;
                    sticky   <= 1'b0;
                    spec     <= dec_spec;
                    spec_res <= dec_res;
                    spec_inv <= dec_inv;
                    spec_inx <= dec_inx;
                end
                SHIFT: begin
                    if (cnt != 6'd0) begin
                        mag    <= mag >> 1;
                        cnt    <= cnt - 6'd1;
                        guard  <= mag[0];
                        sticky <= sticky | guard;
                    end
                end
                FINISH: begin
                    result  <= fin_res;
                    invalid <= fin_inv;
                    inexact <= fin_inx;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int_converter.sv
// Scoreboard bench for float_to_int_converter: table of conversions, handshake and reset scenarios.
// Expected values follow the FLOAT_TO_INT_ROUND_EN build setting.
module tb_float_to_int_converter;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] fa, result;
    logic        busy, done, invalid, inexact;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] fa;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];

`ifdef FLOAT_TO_INT_ROUND_EN
    localparam logic [31:0] R_1P5  = 32'd2;
    localparam logic [31:0] R_0P75 = 32'd1;
    localparam logic [7:0]  L_HALF = 8'd35;
`else
    localparam logic [31:0] R_1P5  = 32'd1;
    localparam logic [31:0] R_0P75 = 32'd0;
    localparam logic [7:0]  L_HALF = 8'd3;
`endif

    localparam int NTBL = 17;
    localparam exp_t TBL [NTBL] = '{
        '{32'h3FC0_0000, R_1P5,        1'b0, 1'b1, 8'd34},
        '{32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b1, 8'd28},
        '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 8'd3},
        '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 8'd3},
        '{32'h7FC0_0000, 32'h0000_0000, 1'b1, 1'b0, 8'd3},
        '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 8'd3},
        '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 8'd3},
        '{32'h3F40_0000, R_0P75,        1'b0, 1'b1, L_HALF},
        '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, L_HALF},
        '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 8'd3},
        '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 8'd3},
        '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 8'd4},
        '{32'hC040_0000, 32'hFFFF_FFFD, 1'b0, 1'b0, 8'd33},
        '{32'hCF80_0000, 32'h8000_0000, 1'b1, 1'b0, 8'd3},
        '{32'h3E80_0000, 32'h0000_0000, 1'b0, 1'b1, 8'd3},
        '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 8'd3},
        '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 8'd34}
    };

    always #5 clk = ~clk;

    float_to_int_converter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .fa      (fa),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .invalid (invalid),
        .inexact (inexact)
    );

    // Called #1 after an edge: pushes the expectation, drives start across the next edge.
    task automatic issue(input exp_t e);
        sb.push_back(e);
        fa    = e.fa;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic await_done(input int from, output int lat, output bit ok);
        lat = from;
        ok  = 1'b0;
        while (!ok && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        fa    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({result, busy, done, invalid, inexact} !== 36'd0) begin
            errors++;
            $display("FAIL reset_state: result=%h busy=%b done=%b invalid=%b inexact=%b, expected all 0",
                     result, busy, done, invalid, inexact);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_conversions();
        exp_t e;
        int   lat;
        bit   ok;
        for (int i = 0; i < NTBL; i++) begin
            issue(TBL[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_start fa=%h: busy=%b, expected 1", TBL[i].fa, busy);
            end
            await_done(0, lat, ok);
            e = sb.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL done_timeout fa=%h: no done within %0d edges", e.fa, lat);
            end else if ({result, invalid, inexact, busy} !== {e.res, e.inv, e.inx, 1'b0}) begin
                errors++;
                $display("FAIL convert fa=%h: result=%h inv=%b inx=%b busy=%b, expected %h inv=%b inx=%b busy=0",
                         e.fa, result, invalid, inexact, busy, e.res, e.inv, e.inx);
            end
            checks++;
            if (lat != int'(e.lat)) begin
                errors++;
                $display("FAIL latency fa=%h: %0d edges, expected %0d", e.fa, lat, e.lat);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse fa=%h: done=%b one cycle later, expected 0", e.fa, done);
            end
        end
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        int   lat;
        bit   ok;
        issue('{32'h3FC0_0000, R_1P5, 1'b0, 1'b1, 8'd34});
        repeat (4) @(posedge clk);
        #1;
        fa    = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_state: busy=%b done=%b, expected busy=1 done=0", busy, done);
        end
        await_done(5, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || result !== e.res || lat != int'(e.lat)) begin
            errors++;
            $display("FAIL busy_ignore_result: done=%b result=%h lat=%0d, expected %h after %0d edges",
                     ok, result, lat, e.res, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        bit seen = 1'b0;
        fa    = 32'h3FC0_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b result=%h, expected 0 0 00000000", busy, done, result);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done seen=%b busy=%b after reset, expected 0 0", seen, busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   ok;
        issue('{32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b1, 8'd28});
        await_done(0, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {result, invalid, inexact} !== {e.res, e.inv, e.inx} || lat != int'(e.lat)) begin
            errors++;
            $display("FAIL b2b_first: done=%b result=%h inv=%b inx=%b lat=%0d, expected %h %b %b %0d",
                     ok, result, invalid, inexact, lat, e.res, e.inv, e.inx, e.lat);
        end
        issue('{32'h3FC0_0000, R_1P5, 1'b0, 1'b1, 8'd34});
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b after start in done cycle, expected 1", busy);
        end
        await_done(0, lat, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {result, invalid, inexact} !== {e.res, e.inv, e.inx} || lat != int'(e.lat)) begin
            errors++;
            $display("FAIL b2b_second: done=%b result=%h inv=%b inx=%b lat=%0d, expected %h %b %b %0d",
                     ok, result, invalid, inexact, lat, e.res, e.inv, e.inx, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
